reg_bank_arb: RTL and testbench
===============================

REG_BANK_ARB -- requirements
Module: reg_bank_arb

Interface
REQ-001 SHALL have parameter MAX_WIDTH, default 8, data width of every bank register.
REQ-002 SHALL have parameter NUM_REGS, default 4, number of bank registers; legal values are powers of two, 2..16.
REQ-003 SHALL have parameter AW, default 2, address width; AW = log2(NUM_REGS).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  2  write request, one bit per requester (bit 0 = requester 0).
REQ-007 SHALL have port addr0 / addr1  input  AW each  target register index per requester.
REQ-008 SHALL have port data0 / data1  input  MAX_WIDTH each  write data per requester.
REQ-009 SHALL have port gnt  output  2  one-hot grant, held for the whole transaction.
REQ-010 SHALL have port ack  output  2  one-cycle completion pulse to the granted requester.
REQ-011 SHALL have port reg_en  output  NUM_REGS  one-hot enable to the bank register enable inputs.
REQ-012 SHALL have port reg_d  output  MAX_WIDTH  shared data bus to all bank register d inputs.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement the FSM IDLE -> GRANT -> WRITE -> ACK -> IDLE, one cycle per state except IDLE.
REQ-015 IDLE: if any req bit is high, SHALL select a winner, latch its addr/data, and go to GRANT; otherwise stay in IDLE.
REQ-016 GRANT: gnt SHALL be one-hot for the winner; reg_d SHALL be driven with the latched data; reg_en SHALL be 0.
REQ-017 WRITE: reg_en[latched addr] SHALL be 1 for exactly one cycle; all other bits 0; reg_d SHALL hold the latched data; gnt SHALL be held.
REQ-018 ACK: ack[winner] SHALL pulse high for one cycle; gnt SHALL be held; reg_en SHALL be 0.
REQ-019 Return to IDLE SHALL drop gnt; reg_d SHALL keep its last value.
REQ-020 Latency SHALL be: req sampled high at edge N -> gnt at N+1, reg_en at N+2, ack at N+3, IDLE at N+4.
REQ-021 Requesters SHALL hold req, addr and data until ack; the block latches them in IDLE, so later changes SHALL NOT affect the transaction.
REQ-022 Deassertion of req mid-transaction SHALL NOT abort the transaction; it SHALL complete through ACK.
REQ-023 A req still high in the cycle after ack SHALL be treated as a new transaction; back-to-back throughput is one write per 4 cycles.
REQ-024 When both req bits are high in IDLE, the winner SHALL be chosen per REQ-030 / REQ-031; the loser SHALL wait with gnt low.
REQ-025 All outputs SHALL be registered; gnt, ack and reg_en SHALL never have more than one bit set.

Reset
REQ-026 Assertion of rst (low) SHALL immediately force state IDLE, gnt=0, ack=0, reg_en=0, reg_d=0 and busy=0, regardless of clk.
REQ-027 Reset mid-transaction SHALL abort it with no reg_en pulse and no ack.
REQ-028 Reset SHALL set the round-robin pointer so that requester 0 has priority.
REQ-029 The first arbitration SHALL be evaluated on the first rising edge after rst deasserts.

Configuration
REQ-030 With macro REG_ARB_ROUND_ROBIN_EN defined, on contention the requester not granted most recently SHALL win; the pointer SHALL update when GRANT is entered.
REQ-031 Without REG_ARB_ROUND_ROBIN_EN, requester 0 SHALL always win contention (fixed priority), and no pointer register SHALL exist.

Verification
REQ-032 Reset, then req=01, addr0=2, data0=8'hA5 at edge 0 -> gnt=01 at edge 1; reg_en=0100 and reg_d=A5 at edge 2; ack=01 at edge 3; busy=0 at edge 4.
REQ-033 Both requesters held high, each for 3 transactions -> with REG_ARB_ROUND_ROBIN_EN the grants alternate 0,1,0,1,0,1; without it requester 0 completes all 3 first.
REQ-034 data0 changed from 8'h11 to 8'h22 after gnt -> reg_d=8'h11 during WRITE.
REQ-035 req0 dropped during GRANT -> transaction still completes, with the reg_en pulse and the ack pulse.
REQ-036 rst asserted in the WRITE cycle between clock edges -> all outputs 0 immediately, with no ack; the next req restarts at GRANT with requester 0 priority.

Source files
------------

// File: rtl/reg_bank_arb_if.sv
// Bus between the two write requesters and the register-bank arbiter.
// master: requester side (drives req/addr/data); slave: arbiter side.
interface reg_bank_arb_if #(
  parameter int unsigned MAX_WIDTH = 8,
  parameter int unsigned NUM_REGS  = 4,
  parameter int unsigned AW        = 2
);
  logic [1:0]           req;
  logic [AW-1:0]        addr0;
  logic [AW-1:0]        addr1;
  logic [MAX_WIDTH-1:0] data0;
  logic [MAX_WIDTH-1:0] data1;
  logic [1:0]           gnt;
  logic [1:0]           ack;
  logic [NUM_REGS-1:0]  reg_en;
  logic [MAX_WIDTH-1:0] reg_d;
  logic                 busy;

  modport master (
    output req, addr0, addr1, data0, data1,
    input  gnt, ack, reg_en, reg_d, busy
  );

  modport slave (
    input  req, addr0, addr1, data0, data1,
    output gnt, ack, reg_en, reg_d, busy
  );
endinterface

// File: rtl/reg_bank_arb.sv
// Two-requester write arbiter for a small register bank.
// Each transaction walks IDLE -> GRANT -> WRITE -> ACK -> IDLE; the winner's addr/data
// are latched in IDLE so requesters may change them afterwards without effect.
// Optional feature: define REG_ARB_ROUND_ROBIN_EN for round-robin contention handling;
// otherwise requester 0 has fixed priority and no pointer register exists.
module reg_bank_arb #(
  parameter int unsigned MAX_WIDTH = 8,
  parameter int unsigned NUM_REGS  = 4,
  parameter int unsigned AW        = 2
) (
  input logic           clk,
  input logic           rst,
  reg_bank_arb_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StGrant, StWrite, StAck} state_e;

  localparam logic [NUM_REGS-1:0] EnOne = NUM_REGS'(1);

  state_e               state_q;
  logic [1:0]           gnt_q;
  logic [1:0]           ack_q;
  logic [NUM_REGS-1:0]  reg_en_q;
  logic [MAX_WIDTH-1:0] reg_d_q;
  logic [AW-1:0]        addr_q;

  // 0 selects requester 0, 1 selects requester 1
  logic win;

`ifdef REG_ARB_ROUND_ROBIN_EN
  // Points at the requester that wins the next contention (the one not granted last).
  logic prio_q;

  // Winner select: pointer decides only when both request.
  always_comb begin
    win = ~bus.req[0];
    if (bus.req == 2'b11) begin
      win = prio_q;
    end
  end

  // Pointer moves to the other requester whenever GRANT is entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q <= 1'b0;
    end else if (state_q == StIdle && (|bus.req)) begin
      prio_q <= ~win;
    end
  end
`else
  // Winner select: requester 0 always wins contention.
  always_comb begin
    win = ~bus.req[0];
  end
`endif

  // Transaction FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      gnt_q    <= 2'b00;
      ack_q    <= 2'b00;
      reg_en_q <= '0;
      reg_d_q  <= '0;
      addr_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|bus.req) begin
            state_q <= StGrant;
            gnt_q   <= win ? 2'b10 : 2'b01;
            addr_q  <= win ? bus.addr1 : bus.addr0;
            reg_d_q <= win ? bus.data1 : bus.data0;
          end
        end
        StGrant: begin
          state_q  <= StWrite;
          reg_en_q <= EnOne << addr_q;
        end
        StWrite: begin
          state_q  <= StAck;
          reg_en_q <= '0;
          ack_q    <= gnt_q;
        end
        StAck: begin
          // reg_d deliberately keeps the last written value
          state_q <= StIdle;
          ack_q   <= 2'b00;
          gnt_q   <= 2'b00;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.ack    = ack_q;
  assign bus.reg_en = reg_en_q;
  assign bus.reg_d  = reg_d_q;
  assign bus.busy   = (state_q != StIdle);

endmodule

// File: tb/tb_reg_bank_arb.sv
// Scoreboard bench for reg_bank_arb: stimulus pushes expected writes, a negedge monitor
// pops and compares whenever an ack appears. Directed checks cover latency and reset.
`timescale 1ns/1ps
module tb_reg_bank_arb;
  localparam int unsigned MW  = 8;
  localparam int unsigned NR  = 4;
  localparam int unsigned AWD = 2;
  localparam logic [NR-1:0] One = NR'(1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_bank_arb_if #(.MAX_WIDTH(MW), .NUM_REGS(NR), .AW(AWD)) bus ();

  reg_bank_arb #(.MAX_WIDTH(MW), .NUM_REGS(NR), .AW(AWD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0]    ack;
    logic [NR-1:0] en;
    logic [MW-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req_v, $time);
    end
  endtask

  function automatic exp_t mk(input int r, input logic [AWD-1:0] a, input logic [MW-1:0] d);
    exp_t e;
    e.ack = (r == 0) ? 2'b01 : 2'b10;
    e.en  = One << a;
    e.d   = d;
    return e;
  endfunction

  // Step to just after the falling edge: outputs are stable there.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ack(output int n, output bit found);
    n = 0;
    found = 1'b0;
    while (!found && n < 12) begin
      tick();
      n++;
      if (bus.ack != 2'b00) found = 1'b1;
    end
    if (!found) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},    32'(bus.gnt),    32'd0);
    chk({tag, "_ack"},    32'(bus.ack),    32'd0);
    chk({tag, "_reg_en"}, 32'(bus.reg_en), 32'd0);
    chk({tag, "_reg_d"},  32'(bus.reg_d),  32'd0);
    chk({tag, "_busy"},   32'(bus.busy),   32'd0);
  endtask

  // Monitor: invariants every cycle, scoreboard compare on each ack.
  logic [NR-1:0] seen_en;
  logic [MW-1:0] seen_d;
  initial begin
    exp_t e;
    seen_en = '0;
    seen_d  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        seen_en = '0;
        seen_d  = '0;
      end else begin
        chk("onehot_gnt",    32'($onehot0(bus.gnt)),    32'd1);
        chk("onehot_ack",    32'($onehot0(bus.ack)),    32'd1);
        chk("onehot_reg_en", 32'($onehot0(bus.reg_en)), 32'd1);
        if (bus.reg_en != '0) begin
          seen_en = bus.reg_en;
          seen_d  = bus.reg_d;
        end
        if (bus.ack != 2'b00) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_ack", 32'(bus.ack), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("sb_ack",    32'(bus.ack), 32'(e.ack));
            chk("sb_gnt",    32'(bus.gnt), 32'(e.ack));
            chk("sb_reg_en", 32'(seen_en), 32'(e.en));
            chk("sb_reg_d",  32'(seen_d),  32'(e.d));
          end
          seen_en = '0;
        end
      end
    end
  end

  initial begin
    int   n;
    bit   found;
    int   ord[6];
    int   cnt[2];
    int   pushed[2];
    logic which;

    bus.req = 2'b00; bus.addr0 = '0; bus.addr1 = '0; bus.data0 = '0; bus.data1 = '0;

    // Reset state
    tick();
    chk_all_zero("reset");
    rst = 1'b1;
    tick();

    // Basic latency: req=01, addr0=2, data0=A5
    bus.req = 2'b01; bus.addr0 = 2'd2; bus.data0 = 8'hA5;
    exp_q.push_back(mk(0, 2'd2, 8'hA5));
    tick();
    chk("lat_gnt_e1",    32'(bus.gnt),    32'h1);
    chk("lat_busy_e1",   32'(bus.busy),   32'h1);
    chk("lat_reg_en_e1", 32'(bus.reg_en), 32'h0);
    chk("lat_reg_d_e1",  32'(bus.reg_d),  32'hA5);
    tick();
    chk("lat_reg_en_e2", 32'(bus.reg_en), 32'h4);
    chk("lat_reg_d_e2",  32'(bus.reg_d),  32'hA5);
    chk("lat_gnt_e2",    32'(bus.gnt),    32'h1);
    tick();
    chk("lat_ack_e3",    32'(bus.ack),    32'h1);
    chk("lat_reg_en_e3", 32'(bus.reg_en), 32'h0);
    bus.req = 2'b00;
    tick();
    chk("lat_busy_e4",   32'(bus.busy),   32'h0);
    chk("lat_gnt_e4",    32'(bus.gnt),    32'h0);
    chk("lat_ack_e4",    32'(bus.ack),    32'h0);
    chk("lat_reg_d_e4",  32'(bus.reg_d),  32'hA5);

    // Data changed after grant must not reach the bank
    bus.req = 2'b01; bus.addr0 = 2'd1; bus.data0 = 8'h11;
    exp_q.push_back(mk(0, 2'd1, 8'h11));
    tick();
    bus.data0 = 8'h22;
    wait_ack(n, found);
    bus.req = 2'b00;
    tick();

    // req dropped during GRANT still completes
    bus.req = 2'b01; bus.addr0 = 2'd3; bus.data0 = 8'h5A;
    exp_q.push_back(mk(0, 2'd3, 8'h5A));
    tick();
    bus.req = 2'b00;
    wait_ack(n, found);
    tick();

    // Requester 1 alone
    bus.req = 2'b10; bus.addr1 = 2'd0; bus.data1 = 8'hC3;
    exp_q.push_back(mk(1, 2'd0, 8'hC3));
    wait_ack(n, found);
    chk("solo1_latency", 32'(n), 32'd3);
    bus.req = 2'b00;
    tick();

    // Reset asserted between edges during WRITE: abort, no ack
    bus.req = 2'b01; bus.addr0 = 2'd2; bus.data0 = 8'h77;
    tick();
    tick();
    chk("abort_in_write", 32'(bus.reg_en), 32'h4);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("abort");
    bus.req = 2'b00;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_abort_reg_en", 32'(bus.reg_en), 32'd0);
      chk("post_abort_ack",    32'(bus.ack),    32'd0);
    end

    // Contention: both hold req for three transactions each
`ifdef REG_ARB_ROUND_ROBIN_EN
    ord = '{0, 1, 0, 1, 0, 1};
`else
    ord = '{0, 0, 0, 1, 1, 1};
`endif
    pushed = '{0, 0};
    for (int k = 0; k < 6; k++) begin
      if (ord[k] == 0) exp_q.push_back(mk(0, 2'd1, 8'(8'h30 + pushed[0])));
      else             exp_q.push_back(mk(1, 2'd3, 8'(8'h40 + pushed[1])));
      pushed[ord[k]]++;
    end
    cnt = '{0, 0};
    bus.addr0 = 2'd1; bus.data0 = 8'h30;
    bus.addr1 = 2'd3; bus.data1 = 8'h40;
    bus.req   = 2'b11;
    for (int k = 0; k < 6; k++) begin
      wait_ack(n, found);
      if (!found) break;
      if (k > 0) chk("b2b_spacing", 32'(n), 32'd4);
      which = bus.ack[1];
      if (!which) begin
        cnt[0]++;
        bus.data0 = 8'(8'h30 + cnt[0]);
        if (cnt[0] == 3) bus.req[0] = 1'b0;
      end else begin
        cnt[1]++;
        bus.data1 = 8'(8'h40 + cnt[1]);
        if (cnt[1] == 3) bus.req[1] = 1'b0;
      end
    end
    bus.req = 2'b00;
    tick();
    tick();
    chk("idle_at_end", 32'(bus.busy), 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time guard
  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
